tmds_encoder_rgb: RTL
=====================

Name: tmds_encoder_rgb

Overview:
- Downstream stage of the HDMI pixel/timing generator. Consumes the 8-bit red/green/blue, hSync, vSync and DrawArea for each pixel.
- Produces three 10-bit TMDS symbols per pixel clock (DVI 1.0 8b/10b), one per channel, for the serializer/output buffers.
- Two-stage pipeline with a per-channel running-disparity counter.
- Channel 0 (blue) carries hSync/vSync during blanking. Channels 1 and 2 send control token 00.

Parameters:
- SYNC_ACTIVE_LOW, 0, when 1 hSync/vSync are inverted before being used as C0/C1 on channel 0.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- red_i  in  8  red pixel data.
- green_i  in  8  green pixel data.
- blue_i  in  8  blue pixel data.
- hSync_i  in  1  horizontal sync, maps to C0 of channel 0.
- vSync_i  in  1  vertical sync, maps to C1 of channel 0.
- DrawArea_i  in  1  data enable; 1 = video period, 0 = control period.
- tmds_ch0_o  out  10  blue/sync symbol, bit 0 transmitted first.
- tmds_ch1_o  out  10  green symbol.
- tmds_ch2_o  out  10  red symbol.
- de_o  out  1  DrawArea_i delayed to align with symbols.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset state:
  - all three outputs = 10'h354 (control token 00);
  - de_o = 0;
  - all disparity counters = 0;
  - pipeline registers cleared (de = 0, ctrl = 00).
  - Reset asserted mid-frame takes effect on the next edge; no partial symbol is emitted.
- Latency: exactly 2 clk cycles, inputs to tmds_*_o and de_o. Throughput: one symbol per channel every cycle, no stalls.
- Stage 1 (per channel, registered):
  - N1 = popcount(D).
  - If N1>4 or (N1==4 and D[0]==0): XNOR chain, q_m[0]=D[0], q_m[i]=q_m[i-1] XNOR D[i], q_m[8]=0.
  - Else: XOR chain, q_m[8]=1.
  - Also register popcount(q_m[7:0]), DrawArea and {C1,C0}.
- Stage 2 (per channel, registered). cnt is a signed 5-bit value, range -8..+8; all arithmetic is signed, no saturation needed. N1/N0 = ones/zeros of q_m[7:0].
  - de=0: output the control token, C1C0 00->10'h354, 01->10'h0AB, 10->10'h154, 11->10'h2AB. cnt <= 0.
  - de=1 and (cnt==0 or N1==N0): out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - de=1 and ((cnt>0 and N1>N0) or (cnt<0 and N0>N1)): out = {1, q_m[8], ~q_m[7:0]}. cnt += 2*q_m[8] + (N0-N1).
  - de=1, otherwise: out = {0, q_m[8], q_m[7:0]}. cnt += -2*(~q_m[8]) + (N1-N0).
- Control mapping:
  - Channel 0: C0 = hSync, C1 = vSync, after optional inversion.
  - Channels 1 and 2: C1C0 = 00.
- Boundary conditions:
  - hSync/vSync are ignored while DrawArea=1.
  - Single-cycle DrawArea pulses are encoded correctly.
  - A 1->0 DrawArea transition clears cnt on that control cycle. The first data pixel after blanking always starts from cnt=0.

Test Plan:
- rst=1 for 3 cycles, then DrawArea=0, syncs 0 -> all outputs 10'h354, de_o=0 from the first post-reset edge.
- DrawArea=0, hSync=1, vSync=0 -> ch0=10'h0AB, ch1=ch2=10'h354 two cycles later. hSync=vSync=1 -> ch0=10'h2AB.
- After blanking, blue=0x00 for 3 pixels -> ch0 sequence 10'h100, 10'h3FF, 10'h100, with cnt -8, +2, -6.
- After blanking, green=0xFF -> ch1=10'h200, cnt=-8. de_o high exactly 2 cycles after DrawArea_i rises.
- Random RGB over a full 640-pixel line -> bit-exact match to the reference model. cnt returns to 0 at blanking, and every cycle's cumulative disparity stays within ±8 plus the current symbol disparity.
- Assert rst mid-line with data active -> next cycle outputs 10'h354, cnt=0. The following pixel encodes as if first after blanking.

Source files
------------

// File: rtl/tmds_encoder_rgb.sv
// DVI 8b/10b TMDS encoder for three RGB channels; blue also carries hSync/vSync in blanking.
// Latency: 2 clk, inputs to symbols and de_o. No backpressure: one symbol per channel every cycle.
module tmds_encoder_rgb #(
  parameter bit SYNC_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] red_i,
  input  logic [7:0] green_i,
  input  logic [7:0] blue_i,
  input  logic       hSync_i,
  input  logic       vSync_i,
  input  logic       DrawArea_i,
  output logic [9:0] tmds_ch0_o,
  output logic [9:0] tmds_ch1_o,
  output logic [9:0] tmds_ch2_o,
  output logic       de_o
);

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  // Transition-minimising stage: qm[8] = 1 marks the XOR chain, 0 the XNOR chain.
  function automatic logic [8:0] transition_min(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm       = 9'd0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8]    = ~use_xnor;
    return qm;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b01:   t = CTRL_01;
      2'b10:   t = CTRL_10;
      2'b11:   t = CTRL_11;
      default: t = CTRL_00;
    endcase
    return t;
  endfunction

  logic [7:0]        pix [3];
  logic [8:0]        qm_d [3];
  logic [8:0]        qm_q [3];
  logic [3:0]        n1_d [3];
  logic [3:0]        n1_q [3];
  logic              de_d, de_q;
  logic [1:0]        ctrl_d, ctrl_q;
  logic [9:0]        sym_d [3];
  logic [9:0]        sym_q [3];
  logic signed [4:0] cnt_d [3];
  logic signed [4:0] cnt_q [3];
  logic signed [4:0] diff [3];
  logic [9:0]        token [3];
  logic              de_o_d, de_o_q;

  assign pix[0] = blue_i;
  assign pix[1] = green_i;
  assign pix[2] = red_i;

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      qm_d[ch] = transition_min(pix[ch]);
      n1_d[ch] = popcount8(qm_d[ch][7:0]);
    end
    de_d   = DrawArea_i;
    ctrl_d = {vSync_i, hSync_i} ^ {2{SYNC_ACTIVE_LOW}};
  end

  // cnt tracks the running ones-minus-zeros disparity of the emitted symbols.
  always_comb begin
    de_o_d = de_q;
    for (int ch = 0; ch < 3; ch++) begin
      sym_d[ch] = sym_q[ch];
      cnt_d[ch] = cnt_q[ch];
      diff[ch]  = $signed({n1_q[ch], 1'b0}) - 5'sd8;
      token[ch] = (ch == 0) ? ctrl_token(ctrl_q) : CTRL_00;
      if (!de_q) begin
        sym_d[ch] = token[ch];
        cnt_d[ch] = 5'sd0;
      end else if ((cnt_q[ch] == 5'sd0) || (diff[ch] == 5'sd0)) begin
        sym_d[ch] = {~qm_q[ch][8], qm_q[ch][8],
                     qm_q[ch][8] ? qm_q[ch][7:0] : ~qm_q[ch][7:0]};
        cnt_d[ch] = cnt_q[ch] + (qm_q[ch][8] ? diff[ch] : -diff[ch]);
      end else if (((cnt_q[ch] > 5'sd0) && (diff[ch] > 5'sd0)) ||
                   ((cnt_q[ch] < 5'sd0) && (diff[ch] < 5'sd0))) begin
        sym_d[ch] = {1'b1, qm_q[ch][8], ~qm_q[ch][7:0]};
        cnt_d[ch] = cnt_q[ch] + (qm_q[ch][8] ? 5'sd2 : 5'sd0) - diff[ch];
      end else begin
        sym_d[ch] = {1'b0, qm_q[ch][8], qm_q[ch][7:0]};
        cnt_d[ch] = cnt_q[ch] - (qm_q[ch][8] ? 5'sd0 : 5'sd2) + diff[ch];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        qm_q[ch]  <= 9'd0;
        n1_q[ch]  <= 4'd0;
        sym_q[ch] <= CTRL_00;
        cnt_q[ch] <= 5'sd0;
      end
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
      de_o_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        qm_q[ch]  <= qm_d[ch];
        n1_q[ch]  <= n1_d[ch];
        sym_q[ch] <= sym_d[ch];
        cnt_q[ch] <= cnt_d[ch];
      end
      de_q   <= de_d;
      ctrl_q <= ctrl_d;
      de_o_q <= de_o_d;
    end
  end

  assign tmds_ch0_o = sym_q[0];
  assign tmds_ch1_o = sym_q[1];
  assign tmds_ch2_o = sym_q[2];
  assign de_o       = de_o_q;

endmodule
